// File: rtl/dram_lsu.sv
// rtl/dram_lsu.sv - load/store sequencer between the hxd32 execute stage and the data RAM port
//
// Accepts one B/H/W access at a time, issues one or two word-aligned DRAM beats
// with lane-shifted byte enables and write data, merges and extends read data,
// and returns exactly one response strobe per accepted request.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake; req_wr_i, req_sel_i, req_addr_i, req_wdata_i
//   rsp_valid_o           one-cycle response strobe with rsp_rdata_o, rsp_err_o
//   dram_valid_o/ready_i  beat handshake; dram_wr_en_o, dram_addr_o,
//                         dram_wr_byte_en_o, dram_wr_data_o, dram_rd_data_i
//
// Build option: DRAM_LSU_MISALIGNED_SPLIT_EN - when defined, word-crossing
// accesses run as two beats; otherwise they are rejected with rsp_err_o.

module dram_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wr_i,
  input  logic [2:0]      req_sel_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            dram_valid_o,
  input  logic            dram_ready_i,
  output logic            dram_wr_en_o,
  output logic [XLEN-1:0] dram_addr_o,
  output logic [3:0]      dram_wr_byte_en_o,
  output logic [XLEN-1:0] dram_wr_data_o,
  input  logic [XLEN-1:0] dram_rd_data_i
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t      state;
  logic        wr_q;
  logic [2:0]  sel_q;
  logic [1:0]  off_q;
`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
  logic            cross_q;
  logic [3:0]      mask_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] asm_q;
  logic [5:0]      hi_sh;
  logic [3:0]      be_hi;
`endif

  // Request decode, used only in IDLE to set up the first beat or the error.
  logic [3:0] mask_in;
  logic [2:0] n_in;
  logic       cross_in;
  logic       err_in;

  always_comb begin
    mask_in = 4'b0001;
    n_in    = 3'd1;
    case (req_sel_i[1:0])
      2'b01:   begin mask_in = 4'b0011; n_in = 3'd2; end
      2'b10:   begin mask_in = 4'b1111; n_in = 3'd4; end
      default: ;
    endcase
    cross_in = ({1'b0, req_addr_i[1:0]} + n_in) > 3'd4;
    // Illegal encodings are 011, 110, 111; unsigned sizes make no sense for stores.
    err_in = (req_sel_i[1] && (req_sel_i[0] || req_sel_i[2])) || (req_wr_i && req_sel_i[2]);
`ifndef DRAM_LSU_MISALIGNED_SPLIT_EN
    err_in = err_in || cross_in;
`endif
  end

  // Low part of the loaded value, right-justified from the first beat.
  logic [XLEN-1:0] rd_lo;
  assign rd_lo = dram_rd_data_i >> {off_q, 3'b000};

`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
  // Second-beat lane shift: the bytes that spilled past the word boundary.
  assign hi_sh = 6'd32 - {1'b0, off_q, 3'b000};
  assign be_hi = mask_q >> (3'd4 - {1'b0, off_q});
`endif

  function automatic logic [XLEN-1:0] extend(input logic [2:0] sel, input logic [XLEN-1:0] v);
    case (sel)
      3'b000:  extend = {{(XLEN-8){v[7]}}, v[7:0]};
      3'b001:  extend = {{(XLEN-16){v[15]}}, v[15:0]};
      3'b100:  extend = {{(XLEN-8){1'b0}}, v[7:0]};
      3'b101:  extend = {{(XLEN-16){1'b0}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      req_ready_o       <= 1'b1;
      rsp_valid_o       <= 1'b0;
      rsp_rdata_o       <= '0;
      rsp_err_o         <= 1'b0;
      dram_valid_o      <= 1'b0;
      dram_wr_en_o      <= 1'b0;
      dram_addr_o       <= '0;
      dram_wr_byte_en_o <= 4'b0000;
      dram_wr_data_o    <= '0;
      wr_q              <= 1'b0;
      sel_q             <= 3'b000;
      off_q             <= 2'b00;
`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
      cross_q           <= 1'b0;
      mask_q            <= 4'b0000;
      wdata_q           <= '0;
      asm_q             <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            wr_q        <= req_wr_i;
            sel_q       <= req_sel_i;
            off_q       <= req_addr_i[1:0];
`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
            cross_q     <= cross_in;
            mask_q      <= mask_in;
            wdata_q     <= req_wdata_i;
            asm_q       <= '0;
`endif
            req_ready_o <= 1'b0;
            if (err_in) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
            end else begin
              state             <= BEAT0;
              dram_valid_o      <= 1'b1;
              dram_wr_en_o      <= req_wr_i;
              dram_addr_o       <= {req_addr_i[XLEN-1:2], 2'b00};
              dram_wr_byte_en_o <= req_wr_i ? (mask_in << req_addr_i[1:0]) : 4'b0000;
              dram_wr_data_o    <= req_wr_i ? (req_wdata_i << {req_addr_i[1:0], 3'b000}) : '0;
            end
          end
        end

        BEAT0: begin
          if (dram_ready_i) begin
            // Default: single-beat access finishes here.
            state             <= RESP;
            dram_valid_o      <= 1'b0;
            dram_wr_en_o      <= 1'b0;
            dram_addr_o       <= '0;
            dram_wr_byte_en_o <= 4'b0000;
            dram_wr_data_o    <= '0;
            rsp_valid_o       <= 1'b1;
            rsp_rdata_o       <= wr_q ? '0 : extend(sel_q, rd_lo);
`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
            if (!wr_q) asm_q <= rd_lo;
            // Crossing access overrides the finish above and issues the second beat.
            if (cross_q) begin
              state             <= BEAT1;
              dram_valid_o      <= 1'b1;
              dram_wr_en_o      <= wr_q;
              dram_addr_o       <= dram_addr_o + XLEN'(4);
              dram_wr_byte_en_o <= wr_q ? be_hi : 4'b0000;
              dram_wr_data_o    <= wr_q ? (wdata_q >> hi_sh) : '0;
              rsp_valid_o       <= 1'b0;
              rsp_rdata_o       <= '0;
            end
`endif
          end
        end

`ifdef DRAM_LSU_MISALIGNED_SPLIT_EN
        BEAT1: begin
          if (dram_ready_i) begin
            state             <= RESP;
            dram_valid_o      <= 1'b0;
            dram_wr_en_o      <= 1'b0;
            dram_addr_o       <= '0;
            dram_wr_byte_en_o <= 4'b0000;
            dram_wr_data_o    <= '0;
            rsp_valid_o       <= 1'b1;
            rsp_rdata_o       <= wr_q ? '0 : extend(sel_q, asm_q | (dram_rd_data_i << hi_sh));
          end
        end
`endif

        RESP: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= '0;
          req_ready_o <= 1'b1;
        end

        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dram_lsu.md
# dram_lsu

- Load/store sequencer between the hxd32 execute stage and the data RAM port.
- Accepts one byte/halfword/word access at a time and converts it into one or two word-aligned DRAM bus beats.
- Drives lane-shifted byte enables and write data, merges and sign/zero-extends read data, and returns one response per request.

## Interface
Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports (clock and reset first):
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_wr_i  in  1  1 = store, 0 = load.
- req_sel_i  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr_i  in  XLEN  byte address.
- req_wdata_i  in  XLEN  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response strobe; no backpressure.
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request rejected; valid only with rsp_valid_o.
- dram_valid_o  out  1  bus beat request.
- dram_ready_i  in  1  beat completes in a cycle where valid and ready are both high.
- dram_wr_en_o  out  1  beat is a write.
- dram_addr_o  out  XLEN  word-aligned beat address; bits [1:0] are always 0.
- dram_wr_byte_en_o  out  4  byte lanes written; 0000 on reads.
- dram_wr_data_o  out  XLEN  lane-aligned write data.
- dram_rd_data_i  in  XLEN  read word; sampled in the cycle the beat completes.

## Operation
State machine: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready_o=1.
  - On handshake, latch wr, sel, addr, wdata.
  - Derive off=addr[1:0], n = 1/2/4 bytes, mask = 0001/0011/1111.
  - Illegal sel (011, 110, 111) or a store with sel 100/101: go to RESP with err=1.
  - Otherwise go to BEAT0.
- BEAT0:
  - dram_addr_o = {addr[31:2],2'b00}.
  - dram_wr_byte_en_o = (mask<<off)[3:0].
  - dram_wr_data_o = wdata<<(8*off).
  - On completion, a load captures rd_data>>(8*off) into the assembly register.
  - If off+n>4 (crossing), go to BEAT1; else go to RESP.
- BEAT1:
  - dram_addr_o = beat0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - dram_wr_byte_en_o = (mask<<off)[7:4].
  - dram_wr_data_o = wdata>>(8*(4-off)).
  - A load merges rd_data<<(8*(4-off)) into the upper bytes.
  - Go to RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then IDLE.
  - Load result: B sign-extends bit 7, H bit 15; BU/HU zero-extend; W is unchanged.
- Non-crossing misaligned accesses (H at off 1) use a single beat and are legal.
- req_ready_o is 0 in every state except IDLE; req_valid_i is ignored there.

## Timing
- All outputs are registered from state and latched fields; there is no combinational path from req_*_i to dram_*_o.
- While dram_valid_o=1 and dram_ready_i=0, all dram_*_o stay stable; dram_valid_o never drops before completion except on reset.
- Latency, with acceptance in cycle N and dram_ready_i tied high:
  - single beat: dram_valid_o in N+1, rsp_valid_o in N+2;
  - split access: beats in N+1 and N+2, rsp_valid_o in N+3;
  - error: rsp_valid_o in N+1, no bus beat.
- Each wait cycle on dram_ready_i adds one cycle of latency.
- Throughput: next request is accepted in the cycle after rsp_valid_o (state IDLE).
- Reset (asynchronous, any state, including mid-BEAT1):
  - state = IDLE;
  - all outputs 0 immediately, except req_ready_o=1 once in IDLE;
  - the partially written access is abandoned and no response is issued.
- Reset values: req_ready_o=1, all other outputs 0, assembly register 0.

## Configuration
- DRAM_LSU_MISALIGNED_SPLIT_EN defined: crossing accesses execute as two beats as above.
- Undefined:
  - a crossing access (H off 3, W off 1-3) goes IDLE→RESP with rsp_err_o=1;
  - no bus beat, latency N+1;
  - BEAT1 logic is not built.
- Non-crossing accesses behave identically with or without the macro.

## Test plan
- SW 0xDEADBEEF to 0x100, ready high → one beat: addr 0x100, be 1111, data 0xDEADBEEF, wr_en 1; rsp_valid_o in N+2, rdata 0, err 0.
- SB 0x000000A5 to 0x103 → addr 0x100, be 1000, data 0xA5000000.
- SH 0x1234 to 0x101 → single beat, be 0110, data 0x00123400.
- LH from 0x102 with word 0x8001_0000 → rdata 0xFFFF8001; LHU → 0x00008001; LB from 0x100 of 0x0000007F → 0x0000007F.
- Macro defined, LW from 0x1FE, word 0x1FC=0xBBAA0000, word 0x200=0x0000DDCC:
  - beats 0x1FC (be 0000, read) then 0x200;
  - rdata 0xDDCCBBAA in N+3.
- Same LW with macro undefined → rsp_err_o=1 in N+1, dram_valid_o never high.
- dram_ready_i low for 5 cycles in BEAT0 → dram_*_o constant, req_ready_o=0, a second req_valid_i is not accepted, rsp_valid_o in N+7.
- rst_n_i pulsed low during BEAT1 of SW 0x1FE:
  - dram_valid_o drops in the same cycle, no rsp_valid_o;
  - after release, req_ready_o=1 and the next SW 0x100 completes normally.
- sel 011 load → rsp_err_o=1, rsp_valid_o in N+1, no beat.
